// File: rtl/rstmgr_req_seq_if.sv
// Request/status bundle around the per-domain reset request sequencer.
// The slave side is the sequencer; the master side drives requests and feeds back status.
interface rstmgr_req_seq_if #(
  parameter int PowerDomains = 2
);
  logic                    esc_req_i;
  logic                    sw_req_i;
  logic [PowerDomains-1:0] pwr_req_i;
  logic [PowerDomains-1:0] rst_status_ni;
  logic [PowerDomains-1:0] rst_req_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;

  modport slave (
    input  esc_req_i, sw_req_i, pwr_req_i, rst_status_ni,
    output rst_req_o, busy_o, done_o, err_o
  );

  modport master (
    output esc_req_i, sw_req_i, pwr_req_i, rst_status_ni,
    input  rst_req_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/rstmgr_req_seq.sv
// Per-power-domain reset request sequencer: merges escalation, software and power-manager
// requests, holds them for a minimum time, then releases Aon first and off domains in order.
module rstmgr_req_seq #(
  parameter int PowerDomains  = 2,
  parameter int HoldCycles    = 16,
  parameter int GapCycles     = 4,
  parameter int TimeoutCycles = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  rstmgr_req_seq_if.slave bus
);

  localparam int PD     = PowerDomains;
  localparam int MaxHG  = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
  localparam int MaxCnt = (MaxHG > TimeoutCycles) ? MaxHG : TimeoutCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam int IdxW   = (PD > 1) ? $clog2(PD) : 1;

  localparam logic [PD-1:0] AllOnes = {PD{1'b1}};
  localparam logic [PD-1:0] OffMask = {PD{1'b1}} << 1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAssert  = 2'd1,
    StHold    = 2'd2,
    StRelease = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [PD-1:0]     tgt_q, tgt_d;
  logic [PD-1:0]     pend_q, pend_d;
  logic [PD-1:0]     rst_req_q, rst_req_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [PD-1:0]     req_mask_s;
  logic [PD-1:0]     new_mask_s;
  logic [PD-1:0]     nxt_mask_s;
  logic [CntW-1:0]   cnt_inc_s;

  function automatic logic [IdxW-1:0] lowest_set(input logic [PD-1:0] m);
    lowest_set = {IdxW{1'b0}};
    for (int i = PD - 1; i >= 0; i--) begin
      lowest_set = m[i] ? IdxW'(i) : lowest_set;
    end
  endfunction

  function automatic logic [PD-1:0] above_mask(input logic [IdxW-1:0] idx);
    for (int i = 0; i < PD; i++) begin
      above_mask[i] = (IdxW'(i) > idx);
    end
  endfunction

  function automatic logic [PD-1:0] onehot(input logic [IdxW-1:0] idx);
    for (int i = 0; i < PD; i++) begin
      onehot[i] = (IdxW'(i) == idx);
    end
  endfunction

  assign req_mask_s = (bus.sw_req_i ? OffMask : {PD{1'b0}}) | bus.pwr_req_i;
  assign new_mask_s = pend_q | {PD{bus.esc_req_i}} | req_mask_s;
  assign nxt_mask_s = tgt_q & above_mask(idx_q);
  assign cnt_inc_s  = cnt_q + CntW'(1);

  // Next-state, target, counter and request computation for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    pend_d    = pend_q;
    rst_req_d = rst_req_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    err_d     = err_q;

    case (state_q)
      StIdle: begin
        rst_req_d = {PD{1'b0}};
        if (new_mask_s != {PD{1'b0}}) begin
          tgt_d     = new_mask_s;
          pend_d    = {PD{1'b0}};
          rst_req_d = new_mask_s;
          cnt_d     = {CntW{1'b0}};
          state_d   = StAssert;
        end else begin
          state_d   = StIdle;
        end
      end

      StAssert: begin
        if (bus.esc_req_i) begin
          tgt_d = AllOnes;
        end else begin
          tgt_d = tgt_q;
        end
        rst_req_d = tgt_d;
        if ((bus.rst_status_ni & tgt_d) == {PD{1'b0}}) begin
          state_d = StHold;
          cnt_d   = {CntW{1'b0}};
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          err_d   = 1'b1;
          state_d = StHold;
          cnt_d   = {CntW{1'b0}};
        end else begin
          cnt_d   = cnt_inc_s;
        end
        pend_d = pend_q | (req_mask_s & ~tgt_d);
      end

      StHold: begin
        cnt_d = (cnt_q < CntW'(HoldCycles)) ? cnt_inc_s : cnt_q;
        if (bus.esc_req_i) begin
          tgt_d     = AllOnes;
          rst_req_d = AllOnes;
        end else if ((cnt_q >= CntW'(HoldCycles)) &&
                     ((bus.pwr_req_i & tgt_q) == {PD{1'b0}})) begin
          // The first targeted domain is released on the way into RELEASE.
          idx_d     = lowest_set(tgt_q);
          rst_req_d = rst_req_q & ~onehot(lowest_set(tgt_q));
          cnt_d     = {CntW{1'b0}};
          gap_d     = 1'b0;
          state_d   = StRelease;
        end else begin
          rst_req_d = tgt_q;
        end
        pend_d = pend_q | (req_mask_s & ~tgt_d);
      end

      StRelease: begin
        if (bus.esc_req_i) begin
          tgt_d     = AllOnes;
          rst_req_d = AllOnes;
          cnt_d     = {CntW{1'b0}};
          gap_d     = 1'b0;
          state_d   = StAssert;
        end else if (!gap_q) begin
          if (bus.rst_status_ni[idx_q] || (cnt_q == CntW'(TimeoutCycles - 1))) begin
            err_d = err_q | ~bus.rst_status_ni[idx_q];
            cnt_d = {CntW{1'b0}};
            if (nxt_mask_s == {PD{1'b0}}) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              gap_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          if (cnt_q >= CntW'(GapCycles)) begin
            idx_d     = lowest_set(nxt_mask_s);
            rst_req_d = rst_req_q & ~onehot(lowest_set(nxt_mask_s));
            cnt_d     = {CntW{1'b0}};
            gap_d     = 1'b0;
          end else begin
            cnt_d     = cnt_inc_s;
          end
        end
        pend_d = pend_q | (req_mask_s & ~tgt_d);
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and output registers; reset starts a full power-on release sequence.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StHold;
      tgt_q     <= AllOnes;
      pend_q    <= {PD{1'b0}};
      rst_req_q <= AllOnes;
      cnt_q     <= {CntW{1'b0}};
      idx_q     <= {IdxW{1'b0}};
      gap_q     <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      pend_q    <= pend_d;
      rst_req_q <= rst_req_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign bus.rst_req_o = rst_req_q;
  assign bus.busy_o    = busy_q;
  assign bus.done_o    = done_q;
  assign bus.err_o     = err_q;

endmodule
